// File: rtl/shift_add_seq_if.sv
// Operand/handshake and partial-product bundle for the shift-add multiplier.
// The slave modport is the multiplier's view; master is the requester's view.
interface shift_add_seq_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      start;
  logic                      abort;
  logic [DATA_WIDTH-1:0]     multiplicand;
  logic [DATA_WIDTH-1:0]     multiplier;
  logic                      busy;
  logic                      en_PPReg;
  logic [2*DATA_WIDTH-1:0]   pp_data;
  logic                      pp_cout;
  logic [2*DATA_WIDTH-1:0]   product;
  logic                      done;

  modport slave (
    input  start, abort, multiplicand, multiplier,
    output busy, en_PPReg, pp_data, pp_cout, product, done
  );

  modport master (
    output start, abort, multiplicand, multiplier,
    input  busy, en_PPReg, pp_data, pp_cout, product, done
  );
endinterface

// File: rtl/shift_add_seq.sv
// Sequential unsigned shift-add multiplier: DATA_WIDTH add-shift iterations per start,
// streaming each partial product {A,Q} to the downstream partial-product register.
module shift_add_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  shift_add_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LastCount = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   a_q, m_q, q_q;
  logic [CW-1:0]           count_q;
  logic                    busy_q, en_q, cout_q, done_q;
  logic [2*DATA_WIDTH-1:0] pp_q, product_q;

  logic [DATA_WIDTH:0]     sum;
  logic                    carry;
  logic [DATA_WIDTH-1:0]   a_next, q_next;

  // One iteration: conditional add kept DATA_WIDTH+1 wide, then shift {C,A,Q} right by one.
  always_comb begin
    sum    = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {(DATA_WIDTH + 1){1'b0}});
    carry  = sum[DATA_WIDTH];
    a_next = {carry, sum[DATA_WIDTH-1:1]};
    q_next = {sum[0], q_q[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      en_q      <= 1'b0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      pp_q      <= '0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            m_q     <= bus.multiplicand;
            q_q     <= bus.multiplier;
            a_q     <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            a_q     <= a_next;
            q_q     <= q_next;
            pp_q    <= {a_next, q_next};
            cout_q  <= carry;
            en_q    <= 1'b1;
            count_q <= count_q + CW'(1);
            if (count_q == LastCount) begin
              product_q <= {a_next, q_next};
              done_q    <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StDone: begin
          // Abort here has the same effect as the normal exit.
          busy_q  <= 1'b0;
          en_q    <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.en_PPReg = en_q;
  assign bus.pp_data  = pp_q;
  assign bus.pp_cout  = cout_q;
  assign bus.product  = product_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_shift_add_seq.sv
// Directed self-checking bench for shift_add_seq (DATA_WIDTH = 8).
module tb_shift_add_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  shift_add_seq_if #(.DATA_WIDTH(8)) bus ();

  shift_add_seq #(.DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (E0), then drop start.
  task automatic launch(input logic [7:0] m, input logic [7:0] q);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    #1;
    outs = {bus.busy, bus.en_PPReg, bus.pp_data, bus.pp_cout, bus.product, bus.done};
    checks++;
    if (outs !== 36'd0) begin
      errors++;
      $display("FAIL reset_init outputs got %h expected 0", outs);
    end
    tick();
    reset_n = 1'b1;
    tick();
    launch(8'h0F, 8'h0F);
    tick(); tick(); tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.en_PPReg !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy got busy=%b en=%b expected 1 1", bus.busy, bus.en_PPReg);
    end
    reset_n = 1'b0;
    #1;
    outs = {bus.busy, bus.en_PPReg, bus.pp_data, bus.pp_cout, bus.product, bus.done};
    checks++;
    if (outs !== 36'd0) begin
      errors++;
      $display("FAIL reset_midcalc outputs got %h expected 0", outs);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.en_PPReg !== 1'b0) begin
        errors++;
        $display("FAIL reset_after cycle %0d got busy=%b done=%b en=%b expected 0 0 0",
                 i, bus.busy, bus.done, bus.en_PPReg);
      end
    end
  endtask

  task automatic test_basic();
    launch(8'd13, 8'd11);
    checks++;
    if (bus.busy !== 1'b1 || bus.en_PPReg !== 1'b0) begin
      errors++;
      $display("FAIL basic_e0 got busy=%b en=%b expected 1 0", bus.busy, bus.en_PPReg);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.en_PPReg !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_en iter %0d got en=%b busy=%b expected 1 1",
                 k, bus.en_PPReg, bus.busy);
      end
      checks++;
      if (bus.done !== (k == 8)) begin
        errors++;
        $display("FAIL basic_done iter %0d got %b expected %b", k, bus.done, (k == 8));
      end
      if (k == 1) begin
        checks++;
        if (bus.product !== 16'h0000) begin
          errors++;
          $display("FAIL basic_product_early got %h expected 0000", bus.product);
        end
      end
    end
    checks++;
    if (bus.product !== 16'h008F) begin
      errors++;
      $display("FAIL basic_product got %h expected 008f", bus.product);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.en_PPReg !== 1'b0 || bus.done !== 1'b0 ||
        bus.product !== 16'h008F) begin
      errors++;
      $display("FAIL basic_exit got busy=%b en=%b done=%b product=%h expected 0 0 0 008f",
               bus.busy, bus.en_PPReg, bus.done, bus.product);
    end
  endtask

  task automatic test_zero_ignore();
    launch(8'h00, 8'hA5);
    tick(); tick(); tick();
    bus.start        = 1'b1;
    bus.multiplicand = 8'hFF;
    bus.multiplier   = 8'hFF;
    tick(); tick();
    bus.start = 1'b0;
    tick(); tick();
    checks++;
    if (bus.done !== 1'b0 || bus.en_PPReg !== 1'b1) begin
      errors++;
      $display("FAIL zero_iter7 got done=%b en=%b expected 0 1", bus.done, bus.en_PPReg);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL zero_product got done=%b product=%h expected 1 0000",
               bus.done, bus.product);
    end
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.product !== 16'h0000) begin
      errors++;
      $display("FAIL zero_exit got busy=%b product=%h expected 0 0000", bus.busy, bus.product);
    end
  endtask

  task automatic test_carry();
    launch(8'hFF, 8'hFF);
    tick();
    checks++;
    if (bus.pp_data !== 16'h7FFF || bus.pp_cout !== 1'b0) begin
      errors++;
      $display("FAIL carry_iter1 got pp=%h cout=%b expected 7fff 0", bus.pp_data, bus.pp_cout);
    end
    tick();
    checks++;
    if (bus.pp_data !== 16'hBF7F || bus.pp_cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_iter2 got pp=%h cout=%b expected bf7f 1", bus.pp_data, bus.pp_cout);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'hFE01 || bus.pp_data !== 16'hFE01) begin
      errors++;
      $display("FAIL carry_product got done=%b product=%h pp=%h expected 1 fe01 fe01",
               bus.done, bus.product, bus.pp_data);
    end
    tick();
  endtask

  task automatic test_abort();
    launch(8'h0F, 8'h0F);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.en_PPReg !== 1'b0 || bus.done !== 1'b0 ||
        bus.product !== 16'hFE01) begin
      errors++;
      $display("FAIL abort_exit got busy=%b en=%b done=%b product=%h expected 0 0 0 fe01",
               bus.busy, bus.en_PPReg, bus.done, bus.product);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== 16'hFE01) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d got done=%b busy=%b product=%h expected 0 0 fe01",
                 i, bus.done, bus.busy, bus.product);
      end
    end
    launch(8'h02, 8'h03);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'h0006) begin
      errors++;
      $display("FAIL abort_restart got done=%b product=%h expected 1 0006",
               bus.done, bus.product);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    launch(8'h05, 8'h07);
    for (int i = 0; i < 7; i++) tick();
    bus.start        = 1'b1;
    bus.multiplicand = 8'h09;
    bus.multiplier   = 8'h0A;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'h0023) begin
      errors++;
      $display("FAIL b2b_first got done=%b product=%h expected 1 0023", bus.done, bus.product);
    end
    // start held through the DONE cycle must be ignored at the DONE exit edge.
    bus.multiplicand = 8'h03;
    bus.multiplier   = 8'h04;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_ignored got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b expected 1", bus.busy);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.product !== 16'h000C) begin
      errors++;
      $display("FAIL b2b_second got done=%b product=%h expected 1 000c", bus.done, bus.product);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_exit got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.multiplicand = 8'h00;
    bus.multiplier   = 8'h00;
    test_reset();
    test_basic();
    test_zero_ignore();
    test_carry();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_seq.md
Name: shift_add_seq

Overview:
Sequential shift-add multiplier datapath and controller. It sits directly upstream of the partial-product register stage and drives that stage's inData/cin/en_PPReg inputs once per iteration. It accepts an unsigned multiplicand/multiplier pair on a start strobe and runs DATA_WIDTH add-shift iterations. It then presents the final 2*DATA_WIDTH-bit product with a one-cycle done pulse.

Parameters:
DATA_WIDTH, 8, operand width in bits; product and partial-product width is 2*DATA_WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE.
multiplicand  input  DATA_WIDTH  operand M, unsigned.
multiplier  input  DATA_WIDTH  operand Q, unsigned.
busy  output  1  high whenever state is not IDLE.
en_PPReg  output  1  partial product valid this cycle; drives downstream enable.
pp_data  output  2*DATA_WIDTH  current {A,Q} after the latest iteration; drives downstream inData.
pp_cout  output  1  carry out of the latest iteration's add; drives downstream cin.
product  output  2*DATA_WIDTH  final result; held until the next start is accepted.
done  output  1  one-cycle pulse when product is updated.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE.
  - Internal registers cleared: A=0, C=0, M=0, Q=0, count=0.
  - All outputs driven 0: busy, en_PPReg, pp_data, pp_cout, product, done.
  - No output is ever driven to Z or X.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - On a rising edge with start=1 (edge E0): load M<=multiplicand, Q<=multiplier, A<=0, C<=0, count<=0. Go to CALC.
  - If start=0, remain in IDLE.
- CALC: each rising edge Ek (k=1..DATA_WIDTH) performs one iteration.
  - If Q[0]=1: {C,A} = A + M, computed DATA_WIDTH+1 bits wide. Otherwise C=0 and A is unchanged.
  - Then logical right shift of {C,A,Q} by one bit. The new A MSB is C, and the new Q MSB is the old A LSB.
  - Register pp_data <= post-shift {A,Q}, pp_cout <= C before the shift, en_PPReg <= 1, count <= count+1.
  - At edge E_DATA_WIDTH (count reaches DATA_WIDTH): product <= post-shift {A,Q}, done <= 1. Go to DONE.
- DONE (one cycle): at the next edge, en_PPReg <= 0, done <= 0. Go to IDLE.
- Timing:
  - en_PPReg is high for exactly DATA_WIDTH consecutive cycles, starting the cycle after E1.
  - done is high for exactly 1 cycle, coincident with the last en_PPReg cycle.
  - busy is high for DATA_WIDTH+1 cycles.
  - Minimum start-to-start spacing is DATA_WIDTH+2 cycles.
- Input sampling:
  - start is ignored while busy, including in DONE.
  - Operands are sampled only at E0; later operand changes have no effect.
- Zero operands: the block still runs the full DATA_WIDTH iterations with no early exit. product=0.
- abort=1 in CALC or DONE:
  - At the next edge go to IDLE and clear en_PPReg, done and busy.
  - product keeps its previous value.
  - abort in IDLE has no effect. abort has priority over start on the same edge.
- Reset mid-operation: immediate return to reset values; no partial product or done is emitted afterwards.
- Widths: the add never overflows, because the carry is kept in C. The final product is exact for all unsigned operands (max (2^W-1)^2).

Test Plan:
- Reset: hold reset_n low during CALC -> all outputs 0 immediately; after release, busy=0 and no done pulse appears.
- Basic: M=8'd13, Q=8'd11, start one cycle -> en_PPReg high 8 cycles, done pulse in cycle 9 after E0, product=16'h008F, busy low after 9 cycles.
- Carry path: M=8'hFF, Q=8'hFF -> iteration 1 pp_data=16'h7FFF, pp_cout=0; iteration 2 pp_data=16'hBF7F, pp_cout=1; final product=16'hFE01.
- Zero/ignore: M=8'h00, Q=8'hA5, start -> product=16'h0000 after a full 8 iterations. Raise start again during CALC with M=Q=8'hFF -> ignored; result stays 0.
- Abort: start M=Q=8'h0F, assert abort at iteration 4 -> next cycle busy=0, en_PPReg=0, no done, product retains its prior value. Then start M=8'h02, Q=8'h03 -> product=16'h0006.
- Back-to-back: assert start in the first IDLE cycle after DONE -> accepted; second result correct; start asserted in the DONE cycle itself is not accepted.
